// File: rtl/bcd_serial_add_if.sv
// Bundle between the requesting unit, the digit-serial BCD sequencer and the
// shared single-digit BCD adder. The slave modport is the sequencer side.
interface bcd_serial_add_if #(
    parameter int DIGITS = 4
);
    logic                  start;
    logic [4*DIGITS-1:0]   a;
    logic [4*DIGITS-1:0]   b;
    logic                  cin;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic [4*DIGITS-1:0]   sum;
    logic                  cout;
    logic [3:0]            bcd_a;
    logic [3:0]            bcd_b;
    logic                  bcd_cin;
    logic [3:0]            bcd_sum;
    logic                  bcd_cout;

    modport master (
        output start, a, b, cin, bcd_sum, bcd_cout,
        input  busy, done, err, sum, cout, bcd_a, bcd_b, bcd_cin
    );

    modport slave (
        input  start, a, b, cin, bcd_sum, bcd_cout,
        output busy, done, err, sum, cout, bcd_a, bcd_b, bcd_cin
    );
endinterface

// File: rtl/bcd_serial_add_ctrl.sv
// Multi-digit packed-BCD adder sequencer. Latches two operands on start and
// feeds one digit pair per clock (LSD first) to a shared combinational
// single-digit BCD adder, chaining the decimal carry through a register.
//
// state | meaning
// IDLE  | waiting for start; result outputs hold the last operation
// RUN   | one digit pair presented to the adder per cycle
// DONE  | one-cycle done pulse, result and cout valid
module bcd_serial_add_ctrl #(
    parameter int DIGITS = 4
) (
    input  logic             clk,
    input  logic             rst,
    bcd_serial_add_if.slave  bus
);
    localparam int W    = 4 * DIGITS;
    localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [W-1:0]    opa;
    logic [W-1:0]    opb;
    logic [W-1:0]    sum_r;
    logic [IW-1:0]   idx;
    logic            carry;
    logic            busy_r;
    logic            done_r;
    logic            err_r;
    logic            cout_r;
    logic [3:0]      bcd_a_r;
    logic [3:0]      bcd_b_r;
    logic            bcd_cin_r;

    function automatic logic [3:0] digit_of(input logic [W-1:0] vec, input int k);
        return vec[4*k +: 4];
    endfunction

    function automatic logic has_bad_digit(input logic [W-1:0] vec);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (vec[4*i +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    // Sequencer FSM; adder drive is registered so it is glitch-free and
    // already holds the next digit pair when the state enters/stays in RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            opa       <= '0;
            opb       <= '0;
            sum_r     <= '0;
            idx       <= '0;
            carry     <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
            cout_r    <= 1'b0;
            bcd_a_r   <= '0;
            bcd_b_r   <= '0;
            bcd_cin_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        opa    <= bus.a;
                        opb    <= bus.b;
                        carry  <= bus.cin;
                        idx    <= '0;
                        sum_r  <= '0;
                        cout_r <= 1'b0;
                        busy_r <= 1'b1;
                        if (has_bad_digit(bus.a) || has_bad_digit(bus.b)) begin
                            err_r  <= 1'b1;
                            done_r <= 1'b1;
                            state  <= DONE;
                        end else begin
                            err_r     <= 1'b0;
                            bcd_a_r   <= bus.a[3:0];
                            bcd_b_r   <= bus.b[3:0];
                            bcd_cin_r <= bus.cin;
                            state     <= RUN;
                        end
                    end
                end
                RUN: begin
                    sum_r[4*int'(idx) +: 4] <= bus.bcd_sum;
                    carry                   <= bus.bcd_cout;
                    if (idx == LAST) begin
                        cout_r    <= bus.bcd_cout;
                        done_r    <= 1'b1;
                        bcd_a_r   <= '0;
                        bcd_b_r   <= '0;
                        bcd_cin_r <= 1'b0;
                        state     <= DONE;
                    end else begin
                        idx       <= idx + 1'b1;
                        bcd_a_r   <= digit_of(opa, int'(idx) + 1);
                        bcd_b_r   <= digit_of(opb, int'(idx) + 1);
                        bcd_cin_r <= bus.bcd_cout;
                    end
                end
                DONE: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.err     = err_r;
    assign bus.sum     = sum_r;
    assign bus.cout    = cout_r;
    assign bus.bcd_a   = bcd_a_r;
    assign bus.bcd_b   = bcd_b_r;
    assign bus.bcd_cin = bcd_cin_r;
endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Scoreboard bench for bcd_serial_add_ctrl with a behavioural single-digit
// BCD adder attached to the shared-adder port.
module tb_bcd_serial_add_ctrl;
    localparam int DIGITS = 4;

    typedef struct {
        string       name;
        logic [15:0] sum;
        logic        cout;
        logic        err;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [3:0] da;
        logic [3:0] db;
        logic       c;
    } dig_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;

    exp_t sb_q[$];
    dig_t dg_q[$];
    exp_t e;
    dig_t d;

    bcd_serial_add_if #(.DIGITS(DIGITS)) bus();

    bcd_serial_add_ctrl #(.DIGITS(DIGITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // behavioural shared digit adder
    logic [4:0] add_t;
    assign add_t        = {1'b0, bus.bcd_a} + {1'b0, bus.bcd_b} + {4'd0, bus.bcd_cin};
    assign bus.bcd_cout = (add_t > 5'd9);
    assign bus.bcd_sum  = (add_t > 5'd9) ? 4'(add_t - 5'd10) : add_t[3:0];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // monitor: result scoreboard on done, adder-drive sequence while in RUN
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.done) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    check({e.name, "_sum"},  32'(bus.sum),  32'(e.sum));
                    check({e.name, "_cout"}, 32'(bus.cout), 32'(e.cout));
                    check({e.name, "_err"},  32'(bus.err),  32'(e.err));
                    check({e.name, "_done_cycle"}, 32'(cyc), 32'(e.cyc));
                end
            end
            if (bus.busy && !bus.done) begin
                if (dg_q.size() == 0) begin
                    check("unexpected_run_drive", 1, 0);
                end else begin
                    d = dg_q.pop_front();
                    check("adder_drive", {23'd0, bus.bcd_a, bus.bcd_b, bus.bcd_cin},
                          {23'd0, d.da, d.db, d.c});
                end
            end else begin
                check("adder_idle_zero", {23'd0, bus.bcd_a, bus.bcd_b, bus.bcd_cin}, 32'd0);
            end
        end
    end

    // Drives a start for one cycle; pushes expected results (hand-computed
    // values passed in) and the digit/carry sequence the adder should see.
    task automatic launch(input string name, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic [15:0] exp_sum, input logic exp_cout,
                          input logic exp_err, input bit expect_done);
        exp_t x;
        dig_t y;
        logic c;
        logic [4:0] t;
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.cin   = cin;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        if (!exp_err) begin
            c = cin;
            for (int k = 0; k < DIGITS; k++) begin
                y.da = a[4*k +: 4];
                y.db = b[4*k +: 4];
                y.c  = c;
                dg_q.push_back(y);
                t = {1'b0, y.da} + {1'b0, y.db} + {4'd0, c};
                c = (t > 5'd9);
            end
        end
        if (expect_done) begin
            x.name = name;
            x.sum  = exp_sum;
            x.cout = exp_cout;
            x.err  = exp_err;
            x.cyc  = exp_err ? cyc : cyc + DIGITS;
            sb_q.push_back(x);
        end
    endtask

    // Waits (bounded) for done, then steps into the following IDLE cycle.
    task automatic wait_done(input string name);
        for (int i = 0; i < 20; i++) begin
            if (bus.done) break;
            @(posedge clk);
            #1;
        end
        check({name, "_done_seen"}, 32'(bus.done), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got no end expected end");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {bus.busy, bus.done, bus.err, bus.cout, bus.sum}, 32'd0);
        check("reset_adder", {bus.bcd_a, bus.bcd_b, bus.bcd_cin}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle_busy", 32'(bus.busy), 32'd0);

        launch("carry3", 16'h0999, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b1);
        check("busy_in_run", 32'(bus.busy), 32'd1);
        wait_done("carry3");

        launch("wrap", 16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        wait_done("wrap");
        repeat (2) @(posedge clk);
        #1;
        check("hold_cout", 32'(bus.cout), 32'd1);
        check("hold_sum", 32'(bus.sum), 32'h0000);
        check("hold_busy", 32'(bus.busy), 32'd0);

        launch("mixed", 16'h1234, 16'h5678, 1'b1, 16'h6913, 1'b0, 1'b0, 1'b1);
        wait_done("mixed");

        launch("baddigit", 16'h00A0, 16'h0001, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b1);
        wait_done("baddigit");

        launch("ignore_start", 16'h0999, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.a     = 16'h1111;
        bus.b     = 16'h1111;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done("ignore_start");
        launch("back2back", 16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, 1'b1);
        wait_done("back2back");

        launch("abort", 16'h1234, 16'h5678, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_outputs", {bus.busy, bus.done, bus.err, bus.cout, bus.sum}, 32'd0);
        check("abort_adder", {bus.bcd_a, bus.bcd_b, bus.bcd_cin}, 32'd0);
        dg_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("abort_no_busy", 32'(bus.busy), 32'd0);

        launch("after_abort", 16'h0999, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b1);
        wait_done("after_abort");

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        check("digit_queue_drained", 32'(dg_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/bcd_serial_add_ctrl.md
# bcd_serial_add_ctrl

Sequencer that performs multi-digit packed-BCD addition by time-sharing one external single-digit BCD adder (4-bit A/B, Cin → 4-bit Sum, Cout, combinational). It latches two DIGITS-digit operands on a start request and feeds one digit pair per clock, least-significant first. It chains the carry through a register and assembles the packed result. It sits between a requesting unit (start/done handshake) and the shared digit adder.

## Interface
- DIGITS, default 4: number of BCD digits per operand (≥1); operand width 4*DIGITS.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  4*DIGITS  packed-BCD operand A, digit 0 in [3:0].
- b  input  4*DIGITS  packed-BCD operand B.
- cin  input  1  initial carry-in.
- busy  output  1  high while in RUN or DONE.
- done  output  1  one-cycle completion pulse.
- err  output  1  operand contained a digit >9; valid with done.
- sum  output  4*DIGITS  packed-BCD result.
- cout  output  1  final decimal carry.
- bcd_a  output  4  digit to adder A input.
- bcd_b  output  4  digit to adder B input.
- bcd_cin  output  1  carry to adder Cin.
- bcd_sum  input  4  adder Sum (combinational return).
- bcd_cout  input  1  adder Cout.

## Operation
- States: IDLE, RUN, DONE.
- IDLE, start=1 at edge: latch a, b into operand registers, latch cin into carry register, clear digit index to 0, clear sum register, and check every digit of a and b.
  - Any digit >9: set err=1 and go to DONE; the adder is not used and sum stays 0.
  - Otherwise: set err=0 and go to RUN.
- IDLE, start=0: remain in IDLE. sum, cout and err hold their last values.
- RUN, each edge: write bcd_sum into sum digit slice [index], load carry ← bcd_cout, then increment index. At index = DIGITS-1, go to DONE instead of incrementing.
- DONE: done=1 for exactly one cycle, cout=carry (0 if err). Return to IDLE at the next edge.
- Adder drive in RUN: bcd_a = operand A digit[index], bcd_b = operand B digit[index], bcd_cin = carry register. In all other states, bcd_a, bcd_b and bcd_cin are 0.
- start while busy is ignored; it is neither queued nor able to alter the operands.
- Result width: sum is exactly 4*DIGITS bits. Overflow beyond the top digit is reported only through cout; sum wraps to the low DIGITS digits.
- Reset (async, any state, including mid-RUN) drives:
  - state = IDLE;
  - busy, done, err, cout = 0;
  - sum = 0;
  - index and carry = 0;
  - bcd_a, bcd_b, bcd_cin = 0.
- A partially accumulated result is discarded on reset. No done is produced for an aborted operation.

## Timing
- Start accepted at edge E0. RUN occupies the cycles between E0 and E_DIGITS; digit k is captured at edge E(k+1).
- done is high in the cycle after E_DIGITS, so latency is DIGITS+1 cycles from start to the done cycle. For DIGITS=4, done appears 5 cycles after start.
- Invalid operand: done is high in the cycle after E0 (latency 1).
- sum and cout are registered and stable from the done cycle until the next accepted start. They are cleared at the edge that accepts a new start.
- The earliest back-to-back start is the cycle after done (the IDLE cycle). The minimum operation period is therefore DIGITS+2 cycles.
- The external adder path is combinational within one cycle: bcd_a/bcd_b/bcd_cin → bcd_sum/bcd_cout must settle before the next edge.

## Test plan
- DIGITS=4, a=16'h0999, b=16'h0001, cin=0 → sum=16'h1000, cout=0, err=0. done is high 5 cycles after start. The bench checks carry propagation across three digits.
- a=16'h9999, b=16'h0001, cin=0 → sum=16'h0000, cout=1 (wrap-around overflow).
- a=16'h1234, b=16'h5678, cin=1 → sum=16'h6913, cout=0. The bench also checks the per-cycle bcd_a/bcd_b sequence: 4/8, 3/7, 2/6, 1/5, with bcd_cin values 1, 1, 1, 0.
- a=16'h00A0, b=16'h0001 → err=1, sum=0, cout=0. done is high 1 cycle after start, and bcd_a/bcd_b stay 0 throughout.
- Start with 16'h0999+16'h0001. Pulse start with a=16'h1111 during RUN → the pulse is ignored and the result is still 16'h1000. A start in the cycle after done is accepted.
- Assert rst during the second RUN cycle → outputs are immediately 0, state is IDLE, and no done is produced. A new start then completes normally.
